// File: rtl/lc3_pipeline_stage5.sv
// LC-3 writeback stage: negedge stage latch, posedge commit into the 8x16 register
// file and NZP register, with bypassed decode read ports and a retired-write counter.
module lc3_pipeline_stage5 #(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [19:0]      I_DR,
    input  logic [1:0]       I_WBtype,
    input  logic [15:0]      I_Res,
    input  logic [2:0]       I_CC,
    input  logic [2:0]       rd1_addr,
    input  logic [2:0]       rd2_addr,
    output logic [15:0]      rd1_data,
    output logic [15:0]      rd2_data,
    output logic [2:0]       CC,
    output logic             fw_valid,
    output logic [2:0]       fw_idx,
    output logic [15:0]      fw_data,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]  idx;
    logic [1:0]  wbt;
    logic [15:0] res;
    logic [2:0]  mcc;
    logic [15:0] regs [NREG];

    // pending is set on the falling edge and cleared on the rising edge; a toggle
    // pair keeps each flop owned by exactly one clock edge.
    logic lat_tog;
    logic com_tog;
    logic pending;

    logic unused_dr;
    assign unused_dr = ^I_DR[15:0];

    assign pending = lat_tog ^ com_tog;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            idx     <= 3'd0;
            wbt     <= 2'b00;
            res     <= 16'h0000;
            mcc     <= 3'b000;
            lat_tog <= 1'b0;
        end else if (!stall) begin
            idx     <= I_DR[18:16];
            wbt     <= I_WBtype;
            res     <= I_Res;
            mcc     <= I_CC;
            lat_tog <= com_tog ^ (I_DR[19] & (I_WBtype != 2'b00));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 16'h0000;
            end
            CC      <= 3'b010;
            retired <= '0;
            com_tog <= 1'b0;
        end else if (pending) begin
            regs[idx] <= res;
            com_tog   <= lat_tog;
            retired   <= retired + CNT_W'(1);
            case (wbt)
                2'b10: begin
                    if (res == 16'h0000) begin
                        CC <= 3'b010;
                    end else if (res[15]) begin
                        CC <= 3'b100;
                    end else begin
                        CC <= 3'b001;
                    end
                end
                2'b11:   CC <= mcc;
                default: CC <= CC;
            endcase
        end
    end

    assign rd1_data = (pending && (rd1_addr == idx)) ? res : regs[rd1_addr];
    assign rd2_data = (pending && (rd2_addr == idx)) ? res : regs[rd2_addr];

    assign fw_valid = pending;
    assign fw_idx   = idx;
    assign fw_data  = res;

endmodule

// File: tb/tb_lc3_pipeline_stage5.sv
// Scoreboard bench for the LC-3 writeback stage: stimulus queues expected commits,
// a monitor pops and checks them whenever a pending write is presented.
module tb_lc3_pipeline_stage5;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [19:0] I_DR;
    logic [1:0]  I_WBtype;
    logic [15:0] I_Res;
    logic [2:0]  I_CC;
    logic [2:0]  rd1_addr;
    logic [2:0]  rd2_addr = 3'd0;
    logic [15:0] rd1_data;
    logic [15:0] rd2_data;
    logic [2:0]  CC;
    logic        fw_valid;
    logic [2:0]  fw_idx;
    logic [15:0] fw_data;
    logic [15:0] retired;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
        logic [2:0]  cc;
        logic [15:0] ret;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    lc3_pipeline_stage5 #(.NREG(8), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .I_DR     (I_DR),
        .I_WBtype (I_WBtype),
        .I_Res    (I_Res),
        .I_CC     (I_CC),
        .rd1_addr (rd1_addr),
        .rd2_addr (rd2_addr),
        .rd1_data (rd1_data),
        .rd2_data (rd2_data),
        .CC       (CC),
        .fw_valid (fw_valid),
        .fw_idx   (fw_idx),
        .fw_data  (fw_data),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        I_DR     = 20'h0;
        I_WBtype = 2'b00;
        I_Res    = 16'h0000;
        I_CC     = 3'b000;
    endtask

    // Drives one instruction for one latch edge, returns 1 time unit after that negedge.
    task automatic issue(input logic we, input logic [2:0] idx, input logic [1:0] wbt,
                         input logic [15:0] res, input logic [2:0] mcc,
                         input bit push, input logic [2:0] exp_cc, input logic [15:0] exp_ret);
        exp_t e;
        @(posedge clk);
        #2;
        I_DR     = {we, idx, 16'h0};
        I_WBtype = wbt;
        I_Res    = res;
        I_CC     = mcc;
        if (push) begin
            e.idx  = idx;
            e.data = res;
            e.cc   = exp_cc;
            e.ret  = exp_ret;
            q.push_back(e);
        end
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    // Monitor: a pending write seen after a latch edge must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (fw_valid && !reset) begin
                if (q.size() == 0) begin
                    check("unexpected_write", {31'd0, fw_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("fw_idx", {29'd0, fw_idx}, {29'd0, e.idx});
                    check("fw_data", {16'd0, fw_data}, {16'd0, e.data});
                    rd2_addr = e.idx;
                    #1;
                    check("rd2_bypass", {16'd0, rd2_data}, {16'd0, e.data});
                    @(posedge clk);
                    #1;
                    check("rd2_committed", {16'd0, rd2_data}, {16'd0, e.data});
                    check("cc_after_commit", {29'd0, CC}, {29'd0, e.cc});
                    check("retired_after_commit", {16'd0, retired}, {16'd0, e.ret});
                    check("pending_cleared", {31'd0, fw_valid}, 32'd0);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        rd1_addr = 3'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd1_addr = 3'(i);
            #1;
            check("reset_rd1", {16'd0, rd1_data}, 32'd0);
        end
        check("reset_rd2", {16'd0, rd2_data}, 32'd0);
        check("reset_cc", {29'd0, CC}, 32'h2);
        check("reset_retired", {16'd0, retired}, 32'd0);
        check("reset_fw_valid", {31'd0, fw_valid}, 32'd0);

        // WBt=10, negative result
        issue(1'b1, 3'd3, 2'b10, 16'h8001, 3'b000, 1'b1, 3'b100, 16'd1);

        // WBt=01, bypass on rd1 before commit, CC untouched
        issue(1'b1, 3'd5, 2'b01, 16'h1234, 3'b001, 1'b1, 3'b100, 16'd2);
        rd1_addr = 3'd5;
        #1;
        check("bypass_rd1_r5", {16'd0, rd1_data}, 32'h1234);
        @(posedge clk);
        #1;
        check("committed_rd1_r5", {16'd0, rd1_data}, 32'h1234);

        // WBt=11: memory CC wins over Res-derived
        issue(1'b1, 3'd1, 2'b11, 16'h7FFF, 3'b010, 1'b1, 3'b010, 16'd3);
        // WBt=10 positive and zero
        issue(1'b1, 3'd6, 2'b10, 16'h0042, 3'b100, 1'b1, 3'b001, 16'd4);
        issue(1'b1, 3'd7, 2'b10, 16'h0000, 3'b001, 1'b1, 3'b010, 16'd5);

        // Write enable low with WBtype!=00: no effect
        issue(1'b0, 3'd3, 2'b10, 16'hFFFF, 3'b100, 1'b0, 3'b000, 16'd0);
        @(posedge clk);
        #1;
        rd1_addr = 3'd3;
        #1;
        check("nowe_reg3", {16'd0, rd1_data}, 32'h8001);
        check("nowe_cc", {29'd0, CC}, 32'h2);
        check("nowe_retired", {16'd0, retired}, 32'd5);

        // WBtype=00 with enable: no effect
        issue(1'b1, 3'd4, 2'b00, 16'hBEEF, 3'b001, 1'b0, 3'b000, 16'd0);
        @(posedge clk);
        #1;
        rd1_addr = 3'd4;
        #1;
        check("wbt00_reg4", {16'd0, rd1_data}, 32'h0);
        check("wbt00_retired", {16'd0, retired}, 32'd5);

        // Stall held for 3 latch edges with a different write presented
        issue(1'b1, 3'd2, 2'b10, 16'hABCD, 3'b001, 1'b1, 3'b100, 16'd6);
        stall    = 1'b1;
        I_DR     = {1'b1, 3'd0, 16'h0};
        I_WBtype = 2'b01;
        I_Res    = 16'h9999;
        repeat (3) @(negedge clk);
        #1;
        stall = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        rd1_addr = 3'd0;
        #1;
        check("stall_retired", {16'd0, retired}, 32'd6);
        check("stall_reg0", {16'd0, rd1_data}, 32'h0);
        rd1_addr = 3'd2;
        #1;
        check("stall_reg2", {16'd0, rd1_data}, 32'hABCD);

        // Both read ports on the same pending register
        issue(1'b1, 3'd4, 2'b01, 16'h5555, 3'b010, 1'b1, 3'b100, 16'd7);
        rd1_addr = 3'd4;
        #1;
        check("same_addr_bypass_rd1", {16'd0, rd1_data}, 32'h5555);
        @(posedge clk);
        #1;
        check("same_addr_committed_rd1", {16'd0, rd1_data}, 32'h5555);

        // Reset between latch and commit aborts the write
        issue(1'b1, 3'd3, 2'b10, 16'h0BAD, 3'b001, 1'b0, 3'b000, 16'd0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset    = 1'b0;
        rd1_addr = 3'd3;
        #1;
        check("abort_reg3", {16'd0, rd1_data}, 32'h0);
        check("abort_retired", {16'd0, retired}, 32'd0);
        check("abort_cc", {29'd0, CC}, 32'h2);
        check("abort_fw_valid", {31'd0, fw_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_retired_later", {16'd0, retired}, 32'd0);
        check("abort_reg3_later", {16'd0, rd1_data}, 32'h0);

        repeat (2) @(posedge clk);
        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
